// File: rtl/pdm_pkg.sv
// Shared constants and types for the stereo PDM transmitter.
// Holds the default configuration, the full-scale and accumulator-width helpers derived from the
// PCM width, and the default-width stereo sample-pair struct.
package pdm_pkg;

  localparam int unsigned DefPcmBits    = 16;
  localparam int unsigned DefClkDivLog2 = 6;
  localparam int unsigned DefOsrLog2    = 6;

  // Full scale FS = 2^(pcm_bits-1).
  function automatic int unsigned fs_of(input int unsigned pcm_bits);
    return 32'd1 << (pcm_bits - 1);
  endfunction

  // Two guard bits keep the accumulator inside [-2FS, 2FS) without saturation.
  function automatic int unsigned acc_bits_of(input int unsigned pcm_bits);
    return pcm_bits + 2;
  endfunction

  localparam int unsigned DefFs      = fs_of(DefPcmBits);
  localparam int unsigned DefAccBits = acc_bits_of(DefPcmBits);

  // Stereo pair at the default width; the top re-declares it at its own parameterised width.
  typedef struct packed {
    logic signed [DefPcmBits-1:0] left;
    logic signed [DefPcmBits-1:0] right;
  } pcm_pair_t;

endpackage

// File: rtl/pdm_sd_mod.sv
// First-order sigma-delta modulator for one channel.
// Ports:
//   clk     system clock
//   rst     synchronous active-high reset, clears the accumulator
//   step_i  advance the modulator by one PDM bit
//   x_i     signed PCM input
//   bit_o   current output bit (acc >= 0), valid before the step that consumes it
module pdm_sd_mod
  import pdm_pkg::*;
#(
  parameter int unsigned PCM_BITS = DefPcmBits
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       step_i,
  input  logic signed [PCM_BITS-1:0] x_i,
  output logic                       bit_o
);

  localparam int unsigned AccBits = acc_bits_of(PCM_BITS);
  localparam logic signed [AccBits-1:0] Fs = AccBits'(fs_of(PCM_BITS));

  logic signed [AccBits-1:0] acc_q, acc_d;
  logic signed [AccBits-1:0] x_ext;
  logic signed [AccBits-1:0] fb;

  assign bit_o = ~acc_q[AccBits-1];
  assign x_ext = {{(AccBits - PCM_BITS){x_i[PCM_BITS-1]}}, x_i};
  assign fb    = bit_o ? Fs : -Fs;

  always_comb begin
    acc_d = acc_q;
    if (step_i) begin
      acc_d = acc_q + x_ext - fb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/pdm_stereo_tx.sv
// Stereo PDM transmitter: accepts PCM pairs over valid/ready, runs one sigma-delta modulator per
// channel and drives a single time-multiplexed data line (left while pdm_clk high, right while low).
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   pcm_left/right    signed PCM sample pair
//   pcm_valid/ready   handshake; pair accepted when both are high
//   pdm_clk           generated bit clock (divider MSB)
//   pdm_data          muxed PDM bitstream, changes with each pdm_clk transition
//   sample_tick       pulse when a new pair enters the modulators
//   underrun          pulse when a frame boundary finds no pair pending (after first accept)
module pdm_stereo_tx
  import pdm_pkg::*;
#(
  parameter int unsigned PCM_BITS     = DefPcmBits,
  parameter int unsigned CLK_DIV_LOG2 = DefClkDivLog2,
  parameter int unsigned OSR_LOG2     = DefOsrLog2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [PCM_BITS-1:0] pcm_left,
  input  logic signed [PCM_BITS-1:0] pcm_right,
  input  logic                       pcm_valid,
  output logic                       pcm_ready,
  output logic                       pdm_clk,
  output logic                       pdm_data,
  output logic                       sample_tick,
  output logic                       underrun
);

  typedef struct packed {
    logic signed [PCM_BITS-1:0] left;
    logic signed [PCM_BITS-1:0] right;
  } pair_t;

  // Left step happens just before pdm_clk rises, right step just before it falls.
  localparam logic [CLK_DIV_LOG2-1:0] LeftCnt  = {1'b0, {(CLK_DIV_LOG2 - 1){1'b1}}};
  localparam logic [CLK_DIV_LOG2-1:0] RightCnt = '1;

  logic [CLK_DIV_LOG2-1:0] cnt_q, cnt_d;
  logic [OSR_LOG2-1:0]     frame_q, frame_d;
  pair_t                   hold_q, hold_d;
  pair_t                   active_q, active_d;
  logic                    hold_full_q, hold_full_d;
  logic                    primed_q, primed_d;
  logic                    data_q, data_d;
  logic                    tick_q, tick_d;
  logic                    und_q, und_d;

  logic  left_ev, right_ev, boundary, accept;
  logic  left_bit, right_bit;
  pair_t in_pair;

  assign left_ev   = (cnt_q == LeftCnt);
  assign right_ev  = (cnt_q == RightCnt);
  assign boundary  = left_ev && (frame_q == '0);
  assign pcm_ready = ~hold_full_q & ~rst;
  assign accept    = pcm_valid & pcm_ready;
  assign in_pair   = '{left: pcm_left, right: pcm_right};

  always_comb begin
    cnt_d       = cnt_q + 1'b1;
    frame_d     = right_ev ? frame_q + 1'b1 : frame_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    active_d    = active_q;
    primed_d    = primed_q | accept;
    tick_d      = 1'b0;
    und_d       = 1'b0;

    if (boundary) begin
      if (hold_full_q) begin
        active_d    = hold_q;
        hold_full_d = 1'b0;
        tick_d      = 1'b1;
      end else if (accept) begin
        // Holding register empty: the incoming pair goes straight to the modulators.
        active_d = in_pair;
        tick_d   = 1'b1;
      end else begin
        und_d = primed_q;
      end
    end else if (accept) begin
      hold_d      = in_pair;
      hold_full_d = 1'b1;
    end

    data_d = data_q;
    if (left_ev) begin
      data_d = left_bit;
    end else if (right_ev) begin
      data_d = right_bit;
    end
  end

  // active_d feeds the modulators so the boundary's left step already sees the new sample.
  pdm_sd_mod #(
    .PCM_BITS (PCM_BITS)
  ) u_mod_left (
    .clk    (clk),
    .rst    (rst),
    .step_i (left_ev),
    .x_i    (active_d.left),
    .bit_o  (left_bit)
  );

  pdm_sd_mod #(
    .PCM_BITS (PCM_BITS)
  ) u_mod_right (
    .clk    (clk),
    .rst    (rst),
    .step_i (right_ev),
    .x_i    (active_d.right),
    .bit_o  (right_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      frame_q     <= '0;
      hold_q      <= '0;
      active_q    <= '0;
      hold_full_q <= 1'b0;
      primed_q    <= 1'b0;
      data_q      <= 1'b0;
      tick_q      <= 1'b0;
      und_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      hold_q      <= hold_d;
      active_q    <= active_d;
      hold_full_q <= hold_full_d;
      primed_q    <= primed_d;
      data_q      <= data_d;
      tick_q      <= tick_d;
      und_q       <= und_d;
    end
  end

  assign pdm_clk     = cnt_q[CLK_DIV_LOG2-1];
  assign pdm_data    = data_q;
  assign sample_tick = tick_q;
  assign underrun    = und_q;

endmodule

// File: doc/pdm_stereo_tx.md
Name: pdm_stereo_tx

Overview:
- Transmit-side counterpart of the PDM microphone receive path.
- Accepts stereo PCM sample pairs over a valid/ready handshake and runs one first-order sigma-delta modulator per channel.
- Generates its own pdm_clk and drives one time-multiplexed pdm_data line: left while pdm_clk is high, right while it is low.
- Feeds an external PDM DAC/amplifier, or loops back into the PDM receive/side-sync chain for self-test.

Parameters:
- PCM_BITS, 16, width of signed two's-complement PCM input; FS = 2^(PCM_BITS-1).
- CLK_DIV_LOG2, 6, pdm_clk period = 2^CLK_DIV_LOG2 clk cycles; minimum 2.
- OSR_LOG2, 6, PDM bits per channel per PCM sample = 2^OSR_LOG2; minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pcm_left  in  PCM_BITS  signed left sample
- pcm_right  in  PCM_BITS  signed right sample
- pcm_valid  in  1  sample pair offered
- pcm_ready  out  1  holding register empty; pair accepted when pcm_valid && pcm_ready
- pdm_clk  out  1  generated PDM bit clock
- pdm_data  out  1  muxed PDM bitstream
- sample_tick  out  1  one-cycle pulse when a new pair enters the modulators
- underrun  out  1  one-cycle pulse when a frame boundary finds no pending pair

Behaviour:
- Reset (rst=1 at a clk edge) clears the following:
  - divider counter, frame counter, both accumulators, active and holding samples, holding_full, primed.
  - Outputs after reset: pdm_clk=0, pdm_data=0, sample_tick=0, underrun=0.
  - pcm_ready = !holding_full && !rst, so it is 0 while rst is high and 1 afterwards.
  - Reset mid-frame discards everything, including a pair accepted in the same cycle.
- Divider:
  - CLK_DIV_LOG2-bit counter increments every clk and wraps.
  - pdm_clk = counter MSB, taken directly from the register.
  - Left event: counter == 2^(CLK_DIV_LOG2-1)-1.
  - Right event: counter == 2^CLK_DIV_LOG2-1.
- Output register:
  - On a left event, pdm_data <= left bit; on a right event, pdm_data <= right bit.
  - pdm_data therefore changes on the same clk edge as the corresponding pdm_clk transition and is stable for the whole half-period.
- Frame counter:
  - OSR_LOG2 bits, increments on every right event, wraps.
  - Frame boundary = left event with frame counter == 0.
- Handshake:
  - Accept loads the holding register and sets holding_full.
  - Accept also sets primed, which stays set until reset.
- At a frame boundary:
  - holding_full=1: active <= holding, holding_full <= 0, sample_tick=1.
  - holding_full=0 and an accept occurs in the same cycle: the incoming pair bypasses into active, holding_full stays 0, sample_tick=1, no underrun.
  - holding_full=0 and no accept: active keeps its previous value (the last sample repeats). underrun=1 only if primed=1.
  - The left step at a boundary uses the newly loaded active value.
  - An accept in a non-boundary cycle with holding_full=1 is impossible, because ready is 0.
- Modulator (per channel, stepped on its event):
  - Accumulator is signed, PCM_BITS+2 bits wide.
  - bit = !acc[MSB], i.e. acc >= 0.
  - acc <= acc + sext(x) - (bit ? FS : -FS).
  - acc stays within [-2FS, 2FS), so there is no overflow and no saturation is needed.
  - Input -FS is legal and yields an all-zero stream in steady state.
- Latency: a pair accepted at least one cycle before a boundary affects pdm_data on that boundary's left edge.

Decomposition:
- pdm_pkg holds:
  - default constants PCM_BITS, CLK_DIV_LOG2, OSR_LOG2;
  - FS and accumulator-width localparams, as functions of PCM_BITS;
  - the stereo sample-pair struct typedef.
- Sub-module pdm_sd_mod:
  - Contains one first-order modulator (clk, rst, step, x, bit).
  - Instantiated twice, for left and right.
  - Divider, frame counter, holding/active registers and output mux stay in the top.

Test Plan (PCM_BITS=8, CLK_DIV_LOG2=2, OSR_LOG2=2 unless stated):
- Reset then idle, no pcm_valid:
  - pdm_clk toggles every 2 clk.
  - pdm_data left/right bits are 1,0,1,0,... (x=0 alternation).
  - underrun stays 0 because primed=0.
- Push pair (L=+64, R=0), sampled by a side-sync-style receiver:
  - Left stream repeats 1,0,1,1 (3/4 density) from the next boundary.
  - Right stream stays alternating.
  - sample_tick pulses exactly once.
- Push L=+127, R=-128 for 64 frames:
  - Left ones count of 256 bits lies in 254..256.
  - Right stream is all 0 after its first bit.
- Stop feeding after priming:
  - underrun pulses once per frame (every 16 clk).
  - Output keeps the last sample's pattern.
  - pcm_ready stays 1.
- pcm_valid held high continuously:
  - Exactly one accept per frame.
  - pcm_ready drops after accept and rises on the boundary cycle.
  - The bypass case (accept in the boundary cycle with holding empty) gives sample_tick=1 and underrun=0.
- Assert rst for 1 cycle mid-frame with holding_full=1:
  - The next cycle shows pdm_clk=0, pdm_data=0, pcm_ready=1.
  - The stream restarts the 1,0 pattern with no underrun.
